// File: rtl/riscv_mtimer.sv
// ----------------------------------------------------------------------------
// riscv_mtimer
//   Memory-mapped machine timer on the core's data-memory bus. It holds a
//   64-bit mtime counter with an 8-bit prescaler, a 64-bit mtimecmp compare
//   register and a registered, level-sensitive machine timer interrupt.
//
//   Register map, selected by addr[4:2]:
//     0 MTIME_LO     1 MTIME_HI (returns the snapshot taken by a MTIME_LO read)
//     2 MTIMECMP_LO  3 MTIMECMP_HI
//     4 CTRL         bit 0 EN, bits [15:8] PRESC
//     5 STATUS       bit 0 = (mtime >= mtimecmp), read-only
//     6-7            unmapped: read 0, writes ignored
//
// Ports
//   clk        clock; all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   sel        access request, held with addr/wdata/wen/byte_en until ready
//   addr       byte address (only [4:2] decoded)
//   wdata      write data
//   wen        1 = write, 0 = read
//   byte_en    byte lane enables for writes
//   rdata      read data, non-zero only while ready is high
//   ready      one-cycle completion pulse, the cycle after the request edge
//   timer_irq  registered EN && (mtime >= mtimecmp)
// ----------------------------------------------------------------------------
module riscv_mtimer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sel,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wen,
    input  logic [3:0]            byte_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  timer_irq
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;
    localparam logic [2:0] OFF_STATUS   = 3'd5;

    state_t      state_reg, state_next;
    logic [63:0] mtime_reg, mtime_next;
    logic [63:0] mtimecmp_reg, mtimecmp_next;
    logic        en_reg, en_next;
    logic [7:0]  presc_reg, presc_next;
    logic [7:0]  pcnt_reg, pcnt_next;
    logic [31:0] hi_shadow_reg, hi_shadow_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        irq_reg, irq_next;

    logic        access;
    logic        wr_access;
    logic        rd_access;
    logic [2:0]  reg_idx;
    logic [31:0] wmask;
    logic [31:0] read_val;
    logic        tick;
    logic        cmp_hit;

    // Only addr[4:2] is decoded; the remaining address bits are intentionally unused.
    logic addr_unused;
    assign addr_unused = ^{addr[ADDR_WIDTH-1:5], addr[1:0]};

    // ------------------------------------------------------------------
    // Bus FSM: accept in IDLE, pulse ready in RESP, always return to IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        access     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sel) begin
                    access     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign reg_idx   = addr[4:2];
    assign wr_access = access && wen;
    assign rd_access = access && !wen;

    // Expand byte enables into a bit mask for the read-modify-write merge.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
            assign wmask[8*gi +: 8] = {8{byte_en[gi]}};
        end
    endgenerate

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    assign tick    = en_reg && (pcnt_reg == presc_reg);
    assign cmp_hit = (mtime_reg >= mtimecmp_reg);

    // ------------------------------------------------------------------
    // Register read mux (values before the access edge).
    // ------------------------------------------------------------------
    always_comb begin
        read_val = 32'h0;
        case (reg_idx)
            OFF_MTIME_LO: read_val = mtime_reg[31:0];
            OFF_MTIME_HI: read_val = hi_shadow_reg;
            OFF_CMP_LO:   read_val = mtimecmp_reg[31:0];
            OFF_CMP_HI:   read_val = mtimecmp_reg[63:32];
            OFF_CTRL:     read_val = {16'h0, presc_reg, 7'h0, en_reg};
            OFF_STATUS:   read_val = {31'h0, cmp_hit};
            default:      read_val = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state for the timer registers.
    // ------------------------------------------------------------------
    always_comb begin
        mtime_next     = mtime_reg + {63'h0, tick};
        mtimecmp_next  = mtimecmp_reg;
        en_next        = en_reg;
        presc_next     = presc_reg;
        hi_shadow_next = hi_shadow_reg;
        rdata_next     = 32'h0;
        irq_next       = en_reg && cmp_hit;

        // A write to either mtime half is based on the pre-increment value,
        // so a coincident prescaler tick is dropped for the whole counter.
        if (wr_access && reg_idx == OFF_MTIME_LO) begin
            mtime_next = {mtime_reg[63:32], merge(mtime_reg[31:0], wdata, wmask)};
        end
        if (wr_access && reg_idx == OFF_MTIME_HI) begin
            mtime_next = {merge(mtime_reg[63:32], wdata, wmask), mtime_reg[31:0]};
        end
        if (wr_access && reg_idx == OFF_CMP_LO) begin
            mtimecmp_next = {mtimecmp_reg[63:32], merge(mtimecmp_reg[31:0], wdata, wmask)};
        end
        if (wr_access && reg_idx == OFF_CMP_HI) begin
            mtimecmp_next = {merge(mtimecmp_reg[63:32], wdata, wmask), mtimecmp_reg[31:0]};
        end
        if (wr_access && reg_idx == OFF_CTRL) begin
            if (byte_en[0]) begin
                en_next = wdata[0];
            end
            if (byte_en[1]) begin
                presc_next = wdata[15:8];
            end
        end

        if (rd_access) begin
            rdata_next = read_val;
            if (reg_idx == OFF_MTIME_LO) begin
                hi_shadow_next = mtime_reg[63:32];
            end
        end

        // Prescaler restarts while disabled and on any CTRL write.
        if (!en_reg || (wr_access && reg_idx == OFF_CTRL) || tick) begin
            pcnt_next = 8'h0;
        end else begin
            pcnt_next = pcnt_reg + 8'h1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_reg     <= 64'h0;
            mtimecmp_reg  <= 64'hFFFF_FFFF_FFFF_FFFF;
            en_reg        <= 1'b0;
            presc_reg     <= 8'h0;
            pcnt_reg      <= 8'h0;
            hi_shadow_reg <= 32'h0;
            rdata_reg     <= 32'h0;
            irq_reg       <= 1'b0;
        end else begin
            mtime_reg     <= mtime_next;
            mtimecmp_reg  <= mtimecmp_next;
            en_reg        <= en_next;
            presc_reg     <= presc_next;
            pcnt_reg      <= pcnt_next;
            hi_shadow_reg <= hi_shadow_next;
            rdata_reg     <= rdata_next;
            irq_reg       <= irq_next;
        end
    end

    assign ready     = (state_reg == RESP);
    assign rdata     = rdata_reg;
    assign timer_irq = irq_reg;

endmodule

// File: tb/tb_riscv_mtimer.sv
// ----------------------------------------------------------------------------
// tb_riscv_mtimer
//   Scoreboard bench for riscv_mtimer: each request pushes its expected read
//   data onto a queue; a negedge monitor pops and compares on every ready.
// ----------------------------------------------------------------------------
module tb_riscv_mtimer;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic [3:0]  byte_en;
    logic [31:0] rdata;
    logic        ready;
    logic        timer_irq;

    int unsigned cyc;
    int          total_cnt;
    int          bad_cnt;
    bit          prev_ready;

    // bit 32 = compare rdata, bits [31:0] = expected rdata
    logic [32:0] exp_q[$];

    riscv_mtimer #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .addr      (addr),
        .wdata     (wdata),
        .wen       (wen),
        .byte_en   (byte_en),
        .rdata     (rdata),
        .ready     (ready),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n) begin
            if (ready) begin
                check_val("ready_width", {63'h0, prev_ready}, 64'h0);
                if (exp_q.size() == 0) begin
                    check_val("unexpected_ready", 64'h1, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    if (e[32]) begin
                        check_val("rdata", {32'h0, rdata}, {32'h0, e[31:0]});
                        $display("read  addr=0x%0h rdata=0x%08h exp=0x%08h", addr, rdata, e[31:0]);
                    end else begin
                        $display("write done");
                    end
                end
            end else begin
                check_val("rdata_idle", {32'h0, rdata}, 64'h0);
            end
        end
        prev_ready = ready;
    end

    // Called at a negedge in IDLE; returns at a negedge in IDLE after the pulse.
    task automatic do_req(input bit w, input int off, input logic [31:0] d,
                          input logic [3:0] be, input logic [32:0] e);
        sel     = 1'b1;
        wen     = w;
        addr    = off * 4;
        wdata   = d;
        byte_en = be;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_val("ready_lat", {63'h0, ready}, 64'h1);
        sel = 1'b0;
        wen = 1'b0;
        @(posedge clk);
        #1;
        check_val("ready_pulse", {63'h0, ready}, 64'h0);
        @(negedge clk);
    endtask

    task automatic wr(input int off, input logic [31:0] d, input logic [3:0] be);
        do_req(1'b1, off, d, be, {1'b0, 32'h0});
    endtask

    task automatic rd(input int off, input logic [31:0] e);
        do_req(1'b0, off, 32'h0, 4'h0, {1'b1, e});
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t0, tr;
        logic [63:0] v;

        total_cnt = 0;
        bad_cnt   = 0;
        rst_n     = 1'b0;
        sel       = 1'b0;
        wen       = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
        byte_en   = 4'h0;

        repeat (3) @(negedge clk);
        check_val("rst_ready", {63'h0, ready}, 64'h0);
        check_val("rst_rdata", {32'h0, rdata}, 64'h0);
        check_val("rst_irq", {63'h0, timer_irq}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values of all eight offsets
        rd(0, 32'h0);
        rd(1, 32'h0);
        rd(2, 32'hFFFF_FFFF);
        rd(3, 32'hFFFF_FFFF);
        rd(4, 32'h0);
        rd(5, 32'h0);
        rd(6, 32'h0);
        rd(7, 32'h0);

        // Prescaler 3: one increment per four enabled cycles
        t0 = cyc + 1;
        wr(4, 32'h0000_0301, 4'hF);
        repeat (40) @(negedge clk);
        tr = cyc + 1;
        rd(0, (tr - t0 - 1) / 4);

        // Carry across the LO/HI boundary with snapshot read
        wr(4, 32'h0, 4'hF);
        wr(0, 32'hFFFF_FFFE, 4'hF);
        wr(1, 32'h0, 4'hF);
        t0 = cyc + 1;
        wr(4, 32'h1, 4'hF);
        repeat (2) @(negedge clk);
        tr = cyc + 1;
        v  = 64'hFFFF_FFFE + 64'(tr - t0 - 1);
        rd(0, v[31:0]);
        rd(1, v[63:32]);

        // Interrupt timing
        wr(4, 32'h0, 4'hF);
        wr(2, 32'd20, 4'hF);
        wr(3, 32'h0, 4'hF);
        wr(0, 32'h0, 4'hF);
        wr(1, 32'h0, 4'hF);
        check_val("irq_off", {63'h0, timer_irq}, 64'h0);
        t0 = cyc + 1;
        wr(4, 32'h1, 4'hF);
        while (cyc < t0 + 20) @(negedge clk);
        check_val("irq_pre", {63'h0, timer_irq}, 64'h0);
        @(negedge clk);
        check_val("irq_rise", {63'h0, timer_irq}, 64'h1);
        repeat (3) @(negedge clk);
        check_val("irq_hold", {63'h0, timer_irq}, 64'h1);
        wr(2, 32'hFFFF_FFFF, 4'hF);
        check_val("irq_fall", {63'h0, timer_irq}, 64'h0);

        // Byte-lane merge and unmapped write
        reset_pulse();
        @(negedge clk);
        wr(2, 32'hAABB_CCDD, 4'b0101);
        rd(2, 32'hFFBB_FFDD);
        wr(7, 32'h1234_5678, 4'hF);
        rd(0, 32'h0);
        rd(1, 32'h0);
        rd(2, 32'hFFBB_FFDD);
        rd(3, 32'hFFFF_FFFF);
        rd(4, 32'h0);
        rd(5, 32'h0);
        rd(6, 32'h0);
        rd(7, 32'h0);
        wr(4, 32'hFFFF_FFFF, 4'hF);
        rd(4, 32'h0000_FF01);

        // Continuous sel: ready toggles, then reset during RESP
        repeat (3) exp_q.push_back({1'b1, 32'h0000_FF01});
        sel  = 1'b1;
        wen  = 1'b0;
        addr = 32'd16;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("ready_tgl", {63'h0, ready}, {63'h0, (i % 2 == 0)});
        end
        @(posedge clk);
        #1;
        check_val("ready_resp", {63'h0, ready}, 64'h1);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_ready", {63'h0, ready}, 64'h0);
        check_val("rst_mid_rdata", {32'h0, rdata}, 64'h0);
        sel = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(0, 32'h0);
        rd(1, 32'h0);
        rd(2, 32'hFFFF_FFFF);
        rd(3, 32'hFFFF_FFFF);
        rd(4, 32'h0);
        rd(5, 32'h0);
        check_val("irq_after_rst", {63'h0, timer_irq}, 64'h0);

        repeat (2) @(negedge clk);
        check_val("q_empty", 64'(exp_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/riscv_mtimer.md
# riscv_mtimer

Memory-mapped machine timer that responds on the core's data-memory bus. Provides a 64-bit `mtime` counter with a programmable prescaler, a 64-bit `mtimecmp` compare register and a level timer-interrupt output. It is the responder end of the dmem protocol (`addr`/`wdata`/`wen`/`byte_en`/`rdata`/`ready`). It sits beside `data_memory` in the SoC, and an external address decode selects it through `sel`.

## Interface
- `ADDR_WIDTH`, default `riscv_pkg::ADDR_WIDTH` (32): bus address width.
- `DATA_WIDTH`, default `riscv_pkg::DATA_WIDTH` (32): bus data width; only 32 is supported.
- `clk`  in  1  single clock; all state is updated on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `sel`  in  1  access request from the address decode; the initiator holds it, with `addr`/`wdata`/`wen`/`byte_en`, until it sees `ready`.
- `addr`  in  ADDR_WIDTH  byte address; only `addr[4:2]` is decoded.
- `wdata`  in  DATA_WIDTH  write data.
- `wen`  in  1  1 = write, 0 = read.
- `byte_en`  in  4  byte lane enables for writes; ignored on reads.
- `rdata`  out  DATA_WIDTH  read data; valid only while `ready`=1, otherwise 0.
- `ready`  out  1  one-cycle completion pulse.
- `timer_irq`  out  1  machine timer interrupt, level, registered.

## Operation
- Register map, by `addr[4:2]`:
  - 0: MTIME_LO.
  - 1: MTIME_HI.
  - 2: MTIMECMP_LO.
  - 3: MTIMECMP_HI.
  - 4: CTRL. Bit 0 is EN; bits [15:8] are PRESC; all other bits read 0.
  - 5: STATUS. Bit 0 is the raw compare result `mtime >= mtimecmp`; read-only.
  - 6–7: unmapped. Reads return 0; writes are ignored.
- Writes merge byte-wise: lane i is updated only when `byte_en[i]`=1.
- Read snapshot:
  - A read of MTIME_LO also copies `mtime[63:32]` into `hi_shadow`.
  - A read of MTIME_HI returns `hi_shadow`, not the live value.
  - This gives tear-free LO-then-HI reads.
- Prescaler:
  - An 8-bit counter `pcnt` runs while EN=1.
  - When `pcnt == PRESC`: `mtime` increments and `pcnt` returns to 0. Otherwise `pcnt` increments.
  - PRESC=0 means `mtime` increments every cycle; PRESC=P means one increment every P+1 cycles.
  - `pcnt` is forced to 0 while EN=0 and on any CTRL write.
- `mtime` is an unsigned 64-bit counter and wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
- `timer_irq` is registered each cycle from `EN && (mtime >= mtimecmp)`, an unsigned 64-bit compare of current register values.
- FSM:
  - IDLE: if `sel`=1, perform the access at this edge and go to RESP.
  - RESP: `ready`=1 and `rdata` driven; `sel` is ignored; go to IDLE unconditionally.
  - Back-to-back requests therefore complete at most every 2 cycles.
- Simultaneous write to MTIME_LO/HI and a prescaler tick in the same edge: the write wins on the written lanes. Unwritten lanes take the pre-increment value, so that tick is lost for them (no increment applied).
- Write to EN: takes effect from the next edge. No increment occurs on the writing edge if EN was 0 before it.

## Timing
- Reset values:
  - `mtime` = 0, `mtimecmp` = 0xFFFF_FFFF_FFFF_FFFF, CTRL = 0, `hi_shadow` = 0, `pcnt` = 0.
  - FSM = IDLE, `ready` = 0, `rdata` = 0, `timer_irq` = 0.
- Access latency:
  - Request sampled at edge T (IDLE, `sel`=1); `ready` is high during cycle T+1 only.
  - Read data reflects register values immediately before edge T.
  - Write results are visible from edge T.
- `timer_irq` rises one cycle after `mtime >= mtimecmp` first holds. It falls one cycle after the condition clears (CTRL write, `mtimecmp` raised, or `mtime` written lower).
- Reset asserted mid-access clears `ready` and the FSM immediately. No partial write survives: all registers go to their reset values.

## Test plan
- Reset, then read all eight offsets -> `rdata` = 0, 0, 0xFFFFFFFF, 0xFFFFFFFF, 0, 0, 0, 0; each `ready` pulse is exactly 1 cycle, 1 cycle after request.
- Write CTRL = 0x0000_0301 (PRESC=3, EN=1), wait 40 cycles, read MTIME_LO -> value equals the number of elapsed enabled cycles divided by 4, floored; checked against the bench model exactly.
- Write MTIME_LO = 0xFFFF_FFFE, MTIME_HI = 0, CTRL = 1; after 2 more cycles read LO then HI -> LO and HI form a consistent 64-bit value across the carry (HI = 1 only if LO < 0xFFFF_FFFE); no torn pair.
- MTIMECMP = 20, MTIME = 0, CTRL = 1 -> `timer_irq` rises exactly one cycle after `mtime` reaches 20. Writing MTIMECMP_LO = 0xFFFF_FFFF then drops it one cycle after the write edge.
- Write MTIMECMP_LO = 0xAABBCCDD with `byte_en` = 4'b0101 from reset -> read returns 0xFFBBFFDD. A write to offset 7 leaves all registers unchanged.
- Hold `sel`=1 continuously with reads -> `ready` toggles 1,0,1,0; `rst_n` dropped during RESP -> `ready` = 0 immediately and all registers return to reset values.
